// File: rtl/alu_issue_if.sv
// Request and result handshake bundle between the issue stage and its neighbours.
interface alu_issue_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_cout;
  logic             out_overflow;

  // Status towards writeback
  logic             ovf_sticky;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;

  // Producer/consumer view: drives requests, accepts results
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready, sticky_clr,
    input  in_ready, out_valid, out_result, out_zero, out_cout, out_overflow,
           ovf_sticky, op_count
  );

  // Issue stage view
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready, sticky_clr,
    output in_ready, out_valid, out_result, out_zero, out_cout, out_overflow,
           ovf_sticky, op_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage for the 16-bit combinational ALU: request FIFO, ALU drive,
// registered result slot, sticky overflow and completed-operation counter.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_zero
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  req_t             mem [DEPTH];
  req_t             head;
  req_t             wr_req;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             drain;
  logic             ovf_masked;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_zero_q;
  logic             out_cout_q;
  logic             out_overflow_q;
  logic             ovf_sticky_q;
  logic [CNT_W-1:0] op_count_q;

  assign empty  = (occ == '0);
  assign full   = (occ == OCC_W'(DEPTH));
  // in_ready is registered as !full of the next occupancy, so a push never lands on a full FIFO
  assign push   = bus.in_valid & in_ready_q;
  // The head leaves the FIFO whenever the output slot is free or being drained this cycle
  assign pop    = ~empty & (~out_valid_q | bus.out_ready);
  assign drain  = out_valid_q & bus.out_ready;
  assign head   = mem[rd_ptr];
  assign wr_req = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
  // Overflow only means something for ADD (010) and SUB (110)
  assign ovf_masked = alu_overflow & (head.op[1:0] == 2'b10);

  // Next occupancy from push/pop
  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  // FIFO pointers, occupancy and registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ        <= occ_next;
      in_ready_q <= (occ_next != OCC_W'(DEPTH));
    end
  end

  // FIFO storage; contents are meaningless while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_req;
  end

  // Present the head entry to the ALU, or an all-zero AND when idle
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    if (!empty) begin
      alu_a  = head.a;
      alu_b  = head.b;
      alu_op = head.op;
    end
  end

  // Output slot: capture replaces, drain alone clears valid but keeps data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_cout_q     <= 1'b0;
      out_overflow_q <= 1'b0;
    end else if (pop) begin
      out_valid_q    <= 1'b1;
      out_result_q   <= alu_result;
      out_zero_q     <= alu_zero;
      out_cout_q     <= alu_cout;
      out_overflow_q <= ovf_masked;
    end else if (drain) begin
      out_valid_q    <= 1'b0;
    end
  end

  // Sticky overflow (set beats clear) and accepted-result counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (pop && ovf_masked) begin
        ovf_sticky_q <= 1'b1;
      end else if (bus.sticky_clr) begin
        ovf_sticky_q <= 1'b0;
      end
      if (drain) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_cout     = out_cout_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.ovf_sticky   = ovf_sticky_q;
  assign bus.op_count     = op_count_q;

  // Occupancy never exceeds the FIFO depth
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= OCC_W'(DEPTH));

  // A held result stays put until the consumer takes it
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_result_q)));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached.
module tb_alu_issue_stage;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cout, alu_overflow, alu_zero;

  alu_issue_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero)
  );

  always #5 clk = ~clk;

  // Attached ALU: one adder with b-invert, overflow/carry reported for every op
  logic [15:0] alu_bb;
  logic [16:0] alu_sum;
  logic        alu_less;
  always_comb begin
    alu_bb       = alu_op[2] ? ~alu_b : alu_b;
    alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + 17'(alu_op[2]);
    alu_overflow = (alu_a[15] == alu_bb[15]) && (alu_sum[15] != alu_a[15]);
    alu_cout     = alu_sum[16];
    alu_less     = alu_sum[15] ^ alu_overflow;
    case (alu_op[1:0])
      2'b00:   alu_result = alu_a & alu_bb;
      2'b01:   alu_result = alu_a | alu_bb;
      2'b10:   alu_result = alu_sum[15:0];
      default: alu_result = {15'b0, alu_less};
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  exp_t exp_q[$];
  logic [CNT_W-1:0] model_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: integer arithmetic from the op rules, not the adder bit equations
  function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    exp_t        e;
    int          sa, sb, ex;
    int unsigned bu, sum;
    logic        ovf;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    bu  = op[2] ? (32'h0000FFFF ^ 32'(b)) : 32'(b);
    sum = 32'(a) + bu + (op[2] ? 32'd1 : 32'd0);
    ex  = op[2] ? (sa - sb) : (sa + sb);
    ovf = (ex > 32767) || (ex < -32768);
    case (op[1:0])
      2'b00:   e.res = a & bu[15:0];
      2'b01:   e.res = a | bu[15:0];
      2'b10:   e.res = sum[15:0];
      default: e.res = (ex < 0) ? 16'd1 : 16'd0;
    endcase
    e.c = sum[16];
    e.z = (e.res == 16'd0);
    e.v = (op == 3'b010 || op == 3'b110) ? ovf : 1'b0;
    return e;
  endfunction

  // Push the expected response for every accepted request
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_op));
      accepted++;
    end
  end

  logic        held = 1'b0;
  logic [15:0] held_res;
  logic        held_z, held_c, held_v;
  exp_t        got;

  // Compare every handshaked result against the scoreboard; check hold stability
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", {13'd0, bus.out_result, bus.out_zero, bus.out_cout, bus.out_overflow},
            {13'd0, held_res, held_z, held_c, held_v});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h with no request pending (t=%0t)", bus.out_result, $time);
        end else begin
          got = exp_q.pop_front();
          chk("result", 32'(bus.out_result), 32'(got.res));
          chk("zero", 32'(bus.out_zero), 32'(got.z));
          chk("cout", 32'(bus.out_cout), 32'(got.c));
          chk("overflow", 32'(bus.out_overflow), 32'(got.v));
          if (got.v) chk("sticky_set", 32'(bus.ovf_sticky), 32'd1);
        end
        chk("op_count", 32'(bus.op_count), 32'(model_cnt));
        model_cnt = model_cnt + CNT_W'(1);
      end
      held     = bus.out_valid && !bus.out_ready;
      held_res = bus.out_result;
      held_z   = bus.out_zero;
      held_c   = bus.out_cout;
      held_v   = bus.out_overflow;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) fail_now("send_timeout");
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) fail_now(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  logic [15:0] corners [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                               16'hFFFF, 16'h0005, 16'h00FF, 16'hAAAA};

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 2) == 0) return 16'($urandom);
    return corners[3'($urandom_range(0, 7))];
  endfunction

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_op      = '0;
    bus.out_ready  = 1'b1;
    bus.sticky_clr = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", {13'd0, bus.out_result, bus.out_zero, bus.out_cout, bus.out_overflow}, 32'd0);
    chk("rst_sticky_count", {23'd0, bus.ovf_sticky, bus.op_count}, 32'd0);
    chk("rst_alu_drive", {13'd0, alu_op, alu_a}, 32'd0);
    do_reset();
    @(negedge clk);
    chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    step();

    // ADD overflow and two-edge latency
    send(16'h7FFF, 16'h0001, 3'b010);
    @(negedge clk);
    chk("latency_edge1", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("latency_edge2", 32'(bus.out_valid), 32'd1);
    chk("sticky_after_add", 32'(bus.ovf_sticky), 32'd1);
    wait_idle("idle_add");

    // SUB equal operands, then SLT
    send(16'h0005, 16'h0005, 3'b110);
    send(16'hFFFF, 16'h0001, 3'b111);
    wait_idle("idle_sub_slt");

    // AND with ALU overflow asserted is masked
    bus.sticky_clr = 1'b1;
    step();
    bus.sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(bus.ovf_sticky), 32'd0);
    send(16'h8000, 16'h8000, 3'b000);
    wait_idle("idle_and");
    chk("mask_sticky", 32'(bus.ovf_sticky), 32'd0);

    // Set wins over a simultaneous clear; clear alone then clears
    send(16'h7FFF, 16'h0001, 3'b010);
    bus.sticky_clr = 1'b1;
    step();
    @(negedge clk);
    chk("sticky_race", 32'(bus.ovf_sticky), 32'd1);
    step();
    bus.sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr_alone", 32'(bus.ovf_sticky), 32'd0);
    wait_idle("idle_race");

    // Backpressure: 7 offered, DEPTH+1 accepted, then drained at full rate
    do_reset();
    bus.out_ready = 1'b0;
    acc0 = accepted;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'(16'h1000 + i * 16'h0111);
      bus.in_b     = 16'(i + 1);
      bus.in_op    = (i % 2 == 0) ? 3'b010 : 3'b110;
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(accepted - acc0), 32'd5);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_throughput", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_op_count", 32'(bus.op_count), 32'd5);
    step();

    // Asynchronous reset with queued and held results
    bus.out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 3'b010);
    send(16'h1234, 16'h0F0F, 3'b001);
    send(16'h00FF, 16'h0001, 3'b010);
    send(16'hAAAA, 16'h5555, 3'b001);
    @(negedge clk);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_data", {13'd0, bus.out_result, bus.out_zero, bus.out_cout, bus.out_overflow}, 32'd0);
    chk("async_sticky_count", {23'd0, bus.ovf_sticky, bus.op_count}, 32'd0);
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
    chk("async_alu_drive", {13'd0, alu_op, alu_a}, 32'd0);
    exp_q.delete();
    model_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("post_reset_no_stale", 32'(bus.out_valid), 32'd0);
    end
    chk("post_reset_op_count", 32'(bus.op_count), 32'd0);
    step();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_a      = pick();
      bus.in_b      = pick();
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("idle_random");
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_op_count", 32'(bus.op_count), 32'(model_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
